// File: rtl/shape_plotter.sv
// Rasteriser back end: accepts one draw command (POINT/FILL/OUTLINE/CLEAR) and
// scans its bounding box in raster order, emitting one VGA pixel write per clock.
module shape_plotter #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic           i_clock,
    input  logic           i_reset,
    // Handshake: a command transfers on a rising edge where i_cmd_valid && o_cmd_ready;
    // o_cmd_ready is high only in IDLE and the command fields are held internally after transfer.
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic [1:0]     i_cmd_mode,
    input  logic [X_W-1:0] i_cmd_x1,
    input  logic [X_W-1:0] i_cmd_x2,
    input  logic [Y_W-1:0] i_cmd_y1,
    input  logic [Y_W-1:0] i_cmd_y2,
    input  logic [2:0]     i_cmd_colour,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic [2:0]     o_colour,
    output logic           o_plot,
    output logic           o_busy,
    output logic           o_done,
    output logic [1:0]     o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]     M_POINT   = 2'b00;
    localparam logic [1:0]     M_OUTLINE = 2'b10;
    localparam logic [1:0]     M_CLEAR   = 2'b11;
    localparam logic [X_W-1:0] LX_MAX    = X_W'(X_MAX);
    localparam logic [Y_W-1:0] LY_MAX    = Y_W'(Y_MAX);

    state_t         r_state;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic           r_plot;
    logic [1:0]     r_mode;
    logic [X_W-1:0] r_x1;
    logic [X_W-1:0] r_x2;
    logic [Y_W-1:0] r_y1;
    logic [Y_W-1:0] r_y2;
    logic [2:0]     r_colour;
    logic [X_W-1:0] r_xmin;
    logic [X_W-1:0] r_xmax;
    logic [Y_W-1:0] r_ymin;
    logic [Y_W-1:0] r_ymax;
    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;

    logic [X_W-1:0] w_x1c;
    logic [X_W-1:0] w_x2c;
    logic [Y_W-1:0] w_y1c;
    logic [Y_W-1:0] w_y2c;
    logic [X_W-1:0] w_xmin;
    logic [X_W-1:0] w_xmax;
    logic [Y_W-1:0] w_ymin;
    logic [Y_W-1:0] w_ymax;
    logic           w_row_end;
    logic           w_last;
    logic [X_W-1:0] w_ncx;
    logic [Y_W-1:0] w_ncy;
    logic           w_nsel;

    // Clamping keeps the scan counters inside the screen, so they never wrap.
    assign w_x1c = (r_x1 > LX_MAX) ? LX_MAX : r_x1;
    assign w_x2c = (r_x2 > LX_MAX) ? LX_MAX : r_x2;
    assign w_y1c = (r_y1 > LY_MAX) ? LY_MAX : r_y1;
    assign w_y2c = (r_y2 > LY_MAX) ? LY_MAX : r_y2;

    always_comb begin
        w_xmin = (w_x1c < w_x2c) ? w_x1c : w_x2c;
        w_xmax = (w_x1c < w_x2c) ? w_x2c : w_x1c;
        w_ymin = (w_y1c < w_y2c) ? w_y1c : w_y2c;
        w_ymax = (w_y1c < w_y2c) ? w_y2c : w_y1c;
        case (r_mode)
            M_POINT: begin
                w_xmin = w_x1c;
                w_xmax = w_x1c;
                w_ymin = w_y1c;
                w_ymax = w_y1c;
            end
            M_CLEAR: begin
                w_xmin = '0;
                w_xmax = LX_MAX;
                w_ymin = '0;
                w_ymax = LY_MAX;
            end
            default: ;
        endcase
    end

    // Next raster position and whether it is drawn; plot is registered one step ahead.
    assign w_row_end = (r_cx == r_xmax);
    assign w_last    = w_row_end && (r_cy == r_ymax);
    assign w_ncx     = w_row_end ? r_xmin : r_cx + X_W'(1);
    assign w_ncy     = w_row_end ? r_cy + Y_W'(1) : r_cy;
    assign w_nsel    = (r_mode != M_OUTLINE) ||
                       (w_ncx == r_xmin) || (w_ncx == r_xmax) ||
                       (w_ncy == r_ymin) || (w_ncy == r_ymax);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_mode   <= M_POINT;
            r_x1     <= '0;
            r_x2     <= '0;
            r_y1     <= '0;
            r_y2     <= '0;
            r_colour <= '0;
            r_xmin   <= '0;
            r_xmax   <= '0;
            r_ymin   <= '0;
            r_ymax   <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid && r_ready) begin
                        r_mode   <= i_cmd_mode;
                        r_x1     <= i_cmd_x1;
                        r_x2     <= i_cmd_x2;
                        r_y1     <= i_cmd_y1;
                        r_y2     <= i_cmd_y2;
                        r_colour <= i_cmd_colour;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_xmin  <= w_xmin;
                    r_xmax  <= w_xmax;
                    r_ymin  <= w_ymin;
                    r_ymax  <= w_ymax;
                    r_cx    <= w_xmin;
                    r_cy    <= w_ymin;
                    // The first position is a corner, so it is drawn in every mode.
                    r_plot  <= 1'b1;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_plot  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cx   <= w_ncx;
                        r_cy   <= w_ncy;
                        r_plot <= w_nsel;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_x         = r_cx;
    assign o_y         = r_cy;
    assign o_colour    = r_colour;
    assign o_plot      = r_plot;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_state     = r_state;

endmodule

// File: tb/tb_shape_plotter.sv
// Directed bench for shape_plotter: expected pixels go into a queue, a negedge
// monitor pops and compares each plotted pixel and gathers per-command timing.
module tb_shape_plotter;

  localparam logic [1:0] M_POINT = 2'b00, M_FILL = 2'b01, M_OUTLINE = 2'b10, M_CLEAR = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_SCAN = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_x1, cmd_x2;
  logic [6:0] cmd_y1, cmd_y2;
  logic [2:0] cmd_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
  logic [1:0] state;

  shape_plotter dut (
    .i_clock(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_mode(cmd_mode), .i_cmd_x1(cmd_x1), .i_cmd_x2(cmd_x2),
    .i_cmd_y1(cmd_y1), .i_cmd_y2(cmd_y2), .i_cmd_colour(cmd_colour),
    .o_x(x), .o_y(y), .o_colour(colour), .o_plot(plot), .o_busy(busy),
    .o_done(done), .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  // scoreboard
  logic [17:0] exp_q[$];
  int plot_cnt, busy_cnt, scan_cnt, hole_cnt, setup_cnt, done_cnt;
  int first_plot_cyc, last_setup_cyc, last_done_cyc, hole_x, hole_y;
  bit got_first;

  task automatic push_px(input int px, input int py, input int pc);
    exp_q.push_back({px[7:0], py[6:0], pc[2:0]});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    plot_cnt = 0; busy_cnt = 0; scan_cnt = 0; hole_cnt = 0; setup_cnt = 0; done_cnt = 0;
    first_plot_cyc = -1; last_setup_cyc = -1; last_done_cyc = -1;
    hole_x = -1; hole_y = -1; got_first = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    if (plot) begin
      plot_cnt++;
      if (!got_first) begin
        first_plot_cyc = cyc;
        got_first = 1'b1;
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) expected no plot", x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, colour} !== e) begin
          bad++;
          $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                   x, y, colour, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
    if (busy) busy_cnt++;
    if (state == ST_SCAN) begin
      scan_cnt++;
      if (!plot) begin
        hole_cnt++;
        hole_x = x;
        hole_y = y;
      end
    end
    if (state == ST_SETUP) begin
      setup_cnt++;
      last_setup_cyc = cyc;
      got_first = 1'b0;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic set_cmd(input logic [1:0] m, input logic [7:0] x1, input logic [6:0] y1,
                         input logic [7:0] x2, input logic [6:0] y2, input logic [2:0] c);
    cmd_mode = m; cmd_x1 = x1; cmd_y1 = y1; cmd_x2 = x2; cmd_y2 = y2; cmd_colour = c;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] x1, input logic [6:0] y1,
                      input logic [7:0] x2, input logic [6:0] y2, input logic [2:0] c);
    wait_ready();
    set_cmd(m, x1, y1, x2, y2, c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 25000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_timeout", done_cnt, target);
    @(negedge clk);
    #1;
  endtask

  task automatic point_test(input string tag);
    @(posedge clk); #1 clear_stats();
    push_px(12, 7, 3'b100);
    send(M_POINT, 8'd12, 7'd7, 8'd99, 7'd99, 3'b100);
    wait_done(1);
    chk({tag, "_plots"}, plot_cnt, 1);
    chk({tag, "_busy"}, busy_cnt, 3);
    chk({tag, "_first_plot"}, first_plot_cyc, last_setup_cyc + 1);
    chk({tag, "_done_time"}, last_done_cyc, last_setup_cyc + 2);
    chk({tag, "_ready_back"}, int'(cmd_ready), 1);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int d1;
    clear_stats();
    reset = 1'b1;
    set_cmd(M_FILL, 8'd1, 7'd1, 8'd2, 7'd2, 3'b111);
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_no_accept", setup_cnt, 0);

    point_test("point");

    // FILL with reversed corners
    @(posedge clk); #1 clear_stats();
    push_px(5, 3, 2); push_px(6, 3, 2); push_px(5, 4, 2); push_px(6, 4, 2);
    send(M_FILL, 8'd6, 7'd4, 8'd5, 7'd3, 3'd2);
    wait_done(1);
    chk("fill_plots", plot_cnt, 4);
    chk("fill_busy", busy_cnt, 6);
    chk("fill_q_empty", exp_q.size(), 0);

    // OUTLINE 3x3
    @(posedge clk); #1 clear_stats();
    push_px(10, 10, 1); push_px(11, 10, 1); push_px(12, 10, 1);
    push_px(10, 11, 1); push_px(12, 11, 1);
    push_px(10, 12, 1); push_px(11, 12, 1); push_px(12, 12, 1);
    send(M_OUTLINE, 8'd10, 7'd10, 8'd12, 7'd12, 3'd1);
    wait_done(1);
    chk("outline_scan", scan_cnt, 9);
    chk("outline_plots", plot_cnt, 8);
    chk("outline_holes", hole_cnt, 1);
    chk("outline_hole_x", hole_x, 11);
    chk("outline_hole_y", hole_y, 11);
    chk("outline_busy", busy_cnt, 11);

    // Clamping
    @(posedge clk); #1 clear_stats();
    push_px(158, 118, 6); push_px(159, 118, 6); push_px(158, 119, 6); push_px(159, 119, 6);
    send(M_FILL, 8'd158, 7'd118, 8'd200, 7'd127, 3'd6);
    wait_done(1);
    chk("clamp_plots", plot_cnt, 4);
    chk("clamp_busy", busy_cnt, 6);
    chk("clamp_q_empty", exp_q.size(), 0);

    // CLEAR aborted by reset at the 50th pixel
    @(posedge clk); #1 clear_stats();
    for (int i = 0; i < 50; i++) push_px(i, 0, 3'd5);
    send(M_CLEAR, 8'd3, 7'd3, 8'd4, 7'd4, 3'd5);
    n = 0;
    while (!(plot && x == 8'd49) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("clear_reached_50", int'(plot && x == 8'd49), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_state", int'(state), int'(ST_IDLE));
    repeat (5) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_plots", plot_cnt, 50);
    chk("abort_q_empty", exp_q.size(), 0);

    point_test("point2");

    // cmd_valid held through a 2x2 FILL, second command queued behind it
    @(posedge clk); #1 clear_stats();
    push_px(20, 20, 5); push_px(21, 20, 5); push_px(20, 21, 5); push_px(21, 21, 5);
    push_px(30, 30, 6);
    wait_ready();
    set_cmd(M_FILL, 8'd20, 7'd20, 8'd21, 7'd21, 3'd5);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 set_cmd(M_POINT, 8'd30, 7'd30, 8'd0, 7'd0, 3'd6);
    n = 0;
    while (done_cnt < 1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("held_first_done", done_cnt, 1);
    d1 = last_done_cyc;
    chk("held_no_early_accept", setup_cnt, 1);
    @(posedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(2);
    chk("held_setups", setup_cnt, 2);
    chk("held_accept_time", last_setup_cyc, d1 + 2);
    chk("held_first_plot", first_plot_cyc, last_setup_cyc + 1);
    chk("held_plots", plot_cnt, 5);
    chk("held_q_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
